// File: rtl/logic_iddr_deser_align.sv
// logic_iddr_deser_align: assembles IDDR bit pairs into words and bitslips the word
// boundary until a continuous training pattern is seen LOCK_CNT times in a row.
module logic_iddr_deser_align #(
  parameter int WORD_W = 8,
  parameter logic [WORD_W-1:0] TRAIN_PAT = 8'hA5,
  parameter int LOCK_CNT = 4,
  parameter int ERR_LIMIT = 2,
  localparam int SW = $clog2(WORD_W)
) (
  input  logic              clk_node,
  input  logic              async_rst,
  input  logic              q1,
  input  logic              q2,
  input  logic              train_en,
  output logic [WORD_W-1:0] data_o,
  output logic              data_vld,
  output logic              locked,
  output logic [SW-1:0]     slip_cnt
);
  localparam int PW = $clog2(WORD_W / 2) < 1 ? 1 : $clog2(WORD_W / 2);
  localparam logic [PW-1:0] PH_LAST = PW'(WORD_W / 2 - 1);
  localparam logic [SW-1:0] SLIP_MAX = SW'(WORD_W - 1);
  localparam logic [3:0] LC = 4'(LOCK_CNT);
  localparam logic [3:0] EL = 4'(ERR_LIMIT);
  typedef enum logic [1:0] {HUNT, CHECK, LOCKED} state_t;
  state_t state;
  logic [2*WORD_W-1:0] sr, sr_next;
  logic [PW-1:0] phase;
  logic [WORD_W-1:0] word;
  logic [SW-1:0] slip_inc;
  logic [3:0] match_cnt, err_cnt;
  logic skip, emit, cmp;
  always_comb begin
    sr_next = {sr[2*WORD_W-3:0], q1, q2};
    word = sr_next[slip_cnt +: WORD_W];
    cmp = word == TRAIN_PAT;
    emit = phase == PH_LAST;
    slip_inc = (slip_cnt == SLIP_MAX) ? '0 : slip_cnt + SW'(1);
  end
  // Counters and state only move on emit edges while the partner is training.
  always_ff @(posedge clk_node or posedge async_rst) begin
    if (async_rst) begin
      sr <= '0;
      phase <= '0;
      data_o <= '0;
      data_vld <= 1'b0;
      locked <= 1'b0;
      slip_cnt <= '0;
      match_cnt <= '0;
      err_cnt <= '0;
      skip <= 1'b0;
      state <= HUNT;
    end else begin
      sr <= sr_next;
      phase <= emit ? '0 : phase + PW'(1);
      data_vld <= emit;
      if (emit) data_o <= word;
      if (emit && train_en) begin
        case (state)
          HUNT:
            if (skip) skip <= 1'b0;
            else if (cmp) begin
              match_cnt <= 4'd1;
              state <= (LC == 4'd1) ? LOCKED : CHECK;
              locked <= LC == 4'd1;
            end else begin
              slip_cnt <= slip_inc;
              skip <= 1'b1;
            end
          CHECK:
            if (cmp) begin
              match_cnt <= match_cnt + 4'd1;
              state <= (match_cnt + 4'd1 == LC) ? LOCKED : CHECK;
              locked <= match_cnt + 4'd1 == LC;
            end else begin
              state <= HUNT;
              match_cnt <= '0;
              slip_cnt <= slip_inc;
              skip <= 1'b1;
            end
          LOCKED:
            if (cmp) err_cnt <= '0;
            else if (err_cnt + 4'd1 == EL) begin
              state <= HUNT;
              locked <= 1'b0;
              err_cnt <= '0;
              match_cnt <= '0;
              skip <= 1'b0;
            end else err_cnt <= err_cnt + 4'd1;
          default: state <= HUNT;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_logic_iddr_deser_align.sv
// tb_logic_iddr_deser_align: directed bit streams against a bit-history model of the aligner.
module tb_logic_iddr_deser_align;
  logic clk_node = 1'b0, async_rst = 1'b1, q1 = 1'b0, q2 = 1'b0, train_en = 1'b0;
  logic [7:0] data_o;
  logic data_vld, locked;
  logic [2:0] slip_cnt;
  int total = 0, bad = 0, vld_seen = 0;
  bit bitq[$];
  bit te = 1'b0;

  always #5 clk_node = ~clk_node;

  logic_iddr_deser_align #(.WORD_W(8), .TRAIN_PAT(8'hA5), .LOCK_CNT(4), .ERR_LIMIT(2)) dut (
    .clk_node(clk_node), .async_rst(async_rst), .q1(q1), .q2(q2), .train_en(train_en),
    .data_o(data_o), .data_vld(data_vld), .locked(locked), .slip_cnt(slip_cnt)
  );

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Model: every received bit is kept in time order; a word is simply the 8 bits
  // ending slip bits before the newest one, and alignment follows the training rules.
  bit hist[$];
  int ecnt, m_slip, mode, m_match, m_err;
  bit m_skip, m_vld;
  logic [7:0] m_dout;

  function automatic logic [7:0] window(input int s);
    logic [7:0] r;
    int n = hist.size();
    for (int i = 0; i < 8; i++) begin
      int idx = n - 8 - s + i;
      r[7-i] = (idx >= 0) ? hist[idx] : 1'b0;
    end
    return r;
  endfunction

  task automatic train_step(input bit hit);
    if (mode == 2) begin
      if (hit) m_err = 0;
      else begin
        m_err++;
        if (m_err == 2) begin mode = 0; m_err = 0; m_match = 0; m_skip = 0; end
      end
    end else if (m_skip) m_skip = 0;
    else if (hit) begin
      m_match++;
      mode = (m_match == 4) ? 2 : 1;
    end else begin
      mode = 0; m_match = 0; m_slip = (m_slip + 1) % 8; m_skip = 1;
    end
  endtask

  initial forever begin
    @(posedge clk_node or posedge async_rst);
    if (async_rst) begin
      hist.delete(); ecnt = 0; m_slip = 0; mode = 0; m_match = 0; m_err = 0;
      m_skip = 0; m_vld = 0; m_dout = '0;
    end else begin
      hist.push_back(q1);
      hist.push_back(q2);
      while (hist.size() > 32) hist.delete(0);
      ecnt++;
      m_vld = (ecnt % 4 == 0);
      if (m_vld) begin
        m_dout = window(m_slip);
        if (train_en) train_step(m_dout == 8'hA5);
      end
      #1;
      chk("vld", int'(data_vld), int'(m_vld));
      chk("locked", int'(locked), int'(mode == 2));
      chk("slip", int'(slip_cnt), m_slip);
      chk("data", int'(data_o), int'(m_dout));
    end
  end

  task automatic push_word(input logic [7:0] w, input int n);
    repeat (n) for (int i = 7; i >= 0; i--) bitq.push_back(w[i]);
  endtask

  task automatic push_bits(input int n, input bit rnd);
    repeat (n) bitq.push_back(rnd ? 1'($urandom_range(0, 1)) : 1'b0);
  endtask

  // Called at a falling edge; each pair is sampled by the following rising edge.
  task automatic drive(input int n);
    for (int k = 0; k < n && bitq.size() >= 2; k++) begin
      q1 = bitq.pop_front();
      q2 = bitq.pop_front();
      train_en = te;
      @(negedge clk_node);
      vld_seen += int'(data_vld);
    end
  endtask

  task automatic flush();
    drive(bitq.size() / 2);
  endtask

  task automatic do_reset();
    @(negedge clk_node);
    async_rst = 1'b1;
    bitq.delete();
    q1 = 1'b0;
    q2 = 1'b0;
    repeat (2) @(negedge clk_node);
    async_rst = 1'b0;
  endtask

  initial begin
    repeat (2) @(negedge clk_node);
    #2;
    chk("rst_vld", int'(data_vld), 0);
    chk("rst_locked", int'(locked), 0);
    chk("rst_slip", int'(slip_cnt), 0);
    chk("rst_data", int'(data_o), 0);
    @(negedge clk_node);
    async_rst = 1'b0;
    te = 1'b1;
    push_word(8'hA5, 3); flush();
    chk("aligned_3w_locked", int'(locked), 0);
    push_word(8'hA5, 1); flush();
    chk("aligned_4w_locked", int'(locked), 1);
    chk("aligned_slip", int'(slip_cnt), 0);
    chk("aligned_data", int'(data_o), 8'hA5);
    push_word(8'hFF, 1); flush();
    chk("one_bad_locked", int'(locked), 1);
    push_word(8'hA5, 1); flush();
    chk("bad_then_good_locked", int'(locked), 1);
    push_word(8'hFF, 1); flush();
    chk("first_of_two_bad", int'(locked), 1);
    push_word(8'hFF, 1); flush();
    chk("second_of_two_bad", int'(locked), 0);
    chk("unlock_slip_held", int'(slip_cnt), 0);
    push_word(8'hA5, 4); flush();
    chk("relock", int'(locked), 1);
    push_word(8'hA5, 1); drive(2);
    #2 async_rst = 1'b1;
    #1;
    chk("midrst_vld", int'(data_vld), 0);
    chk("midrst_locked", int'(locked), 0);
    chk("midrst_slip", int'(slip_cnt), 0);
    chk("midrst_data", int'(data_o), 0);
    @(negedge clk_node);
    async_rst = 1'b0;
    bitq.delete();
    push_word(8'hA5, 2);
    drive(3);
    chk("first_vld_early", int'(data_vld), 0);
    drive(1);
    chk("first_vld_at_4", int'(data_vld), 1);
    flush();

    do_reset();
    push_bits(3, 1'b0); push_word(8'hA5, 16); flush();
    chk("mis3_locked", int'(locked), 1);
    chk("mis3_slip", int'(slip_cnt), 5);
    chk("mis3_data", int'(data_o), 8'hA5);

    do_reset();
    push_bits(1, 1'b0); push_word(8'hA5, 20); flush();
    chk("slip7_locked", int'(locked), 1);
    chk("slip7_slip", int'(slip_cnt), 7);
    push_word(8'hFF, 2); push_bits(7, 1'b0); push_word(8'hA5, 8); flush();
    chk("wrap_locked", int'(locked), 1);
    chk("wrap_slip", int'(slip_cnt), 0);

    do_reset();
    push_word(8'hFF, 1); flush();
    te = 1'b0;
    push_bits(72, 1'b1); flush();
    chk("freeze_hunt_slip", int'(slip_cnt), 1);
    chk("freeze_hunt_locked", int'(locked), 0);
    te = 1'b1;
    push_word(8'hA5, 20); flush();
    chk("post_freeze_locked", int'(locked), 1);
    chk("post_freeze_slip", int'(slip_cnt), 0);
    te = 1'b0;
    vld_seen = 0;
    push_bits(80, 1'b1); flush();
    chk("freeze_lock_locked", int'(locked), 1);
    chk("freeze_lock_cadence", vld_seen, 10);
    repeat (2) @(negedge clk_node);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/logic_iddr_deser_align.md
Name: logic_iddr_deser_align

Overview:
- Receive-side word assembler for source-synchronous DDR links driven by the ODDR output primitive at the far end.
- Consumes the two per-cycle bits from the IDDR input primitive (q1 rising-edge sample, q2 falling-edge sample, both already in clk_node domain).
- Deserializes them into WORD_W-bit words.
- Uses a bitslip training FSM to lock the word boundary to a known training pattern.

Parameters:
- WORD_W, 8, output word width; even, 4..16.
- TRAIN_PAT, 8'hA5, training word, WORD_W bits; all WORD_W rotations must be distinct.
- LOCK_CNT, 4, consecutive pattern matches required to declare lock; 1..15.
- ERR_LIMIT, 2, consecutive mismatches while locked and training that drop lock; 1..15.

Ports:
- clk_node  in  1  fabric clock; same clock as the feeding IDDR.
- async_rst  in  1  reset; asynchronous, active-high.
- q1  in  1  IDDR rising-edge bit; the earlier bit in time of each pair.
- q2  in  1  IDDR falling-edge bit; the later bit of each pair.
- train_en  in  1  high while the link partner transmits TRAIN_PAT continuously.
- data_o  out  WORD_W  assembled word; first-received bit at MSB.
- data_vld  out  1  one-cycle strobe per word.
- locked  out  1  word boundary aligned.
- slip_cnt  out  clog2(WORD_W)  current bit offset, 0..WORD_W-1.

Behaviour:
- Reset is decided: async_rst, asynchronous, active-high; clock is clk_node. While async_rst is high, the following are all 0 immediately, not waiting for an edge:
  - sr, phase, data_o, data_vld, locked, slip_cnt, match_cnt, err_cnt, skip.
  - FSM state = HUNT.
- Shift register sr has 2*WORD_W bits. Every edge: sr_next = {sr[2W-3:0], q1, q2}; sr <= sr_next.
- phase counts 0..WORD_W/2-1 every cycle, wraps to 0 and free-runs regardless of FSM state.
- Emit event, on the edge where phase == WORD_W/2-1:
  - data_o <= sr_next[slip_cnt +: WORD_W].
  - data_vld <= 1.
  - data_vld is 0 on all other edges.
- Latency: the word containing the pair sampled at edge E is visible right after E.
- Increasing slip_cnt by 1 moves the boundary one bit earlier in time.
- Word compare, at each emit: cmp = (sr_next[slip_cnt +: WORD_W] == TRAIN_PAT). Evaluated only when train_en = 1.
- FSM states HUNT, CHECK, LOCKED. Transitions occur only at emit edges with train_en = 1; with train_en = 0, state and counters are frozen.
- HUNT:
  - If skip = 1: clear skip, no compare.
  - Else, cmp = 1: go to CHECK, match_cnt = 1.
  - Else, cmp = 0: slip_cnt = (slip_cnt + 1) mod WORD_W, skip = 1.
  - The skip blanks the first word after a slip.
- CHECK:
  - cmp = 1: match_cnt++; when match_cnt reaches LOCK_CNT, go to LOCKED with locked = 1. With LOCK_CNT = 1, go from HUNT directly to LOCKED on the first match.
  - cmp = 0: go to HUNT, match_cnt = 0, slip_cnt++ (wraps), skip = 1.
- LOCKED:
  - locked = 1; slip_cnt is held.
  - train_en = 1 and cmp = 0: err_cnt++.
  - train_en = 1 and cmp = 1: err_cnt = 0.
  - When err_cnt reaches ERR_LIMIT: go to HUNT, locked = 0, err_cnt = 0, match_cnt = 0, slip_cnt unchanged, skip = 0.
  - train_en = 0: no checking; err_cnt is held.
- data_o and data_vld are produced in all states. Downstream qualifies them with locked.
- Simultaneous events: the slip update and data_o capture on the same emit edge both use the pre-update slip_cnt.
- Wrap-around: slip_cnt = WORD_W-1 wraps to 0.
- Guaranteed lock: with a continuous pattern, lock is reached within 2*WORD_W + LOCK_CNT words.

Test Plan:
- Reset: assert async_rst mid-stream while locked -> data_vld, locked, slip_cnt and data_o drop to 0 immediately. First data_vld comes exactly WORD_W/2 edges after release.
- Aligned training: continuous 8'hA5 sent MSB-first, boundary coincident with phase 0, train_en = 1 -> slip_cnt stays 0, locked rises at the 4th emit, data_o = 8'hA5 on every strobe.
- Misaligned by 3 bits: same stream delayed by 3 bits -> slip_cnt settles at the value giving data_o = 8'hA5, locked within 20 words, and slip_cnt does not change after lock.
- Wrap: stream offset requiring slip 7 after a start at 7 -> slip_cnt wraps 7 -> 0 and continues to lock.
- Loss of lock: while locked, inject 2 consecutive corrupted words (8'hFF) with train_en = 1 -> locked falls after the 2nd. A single corrupted word followed by a good one keeps locked = 1.
- Freeze: train_en = 0 with random data in HUNT -> slip_cnt and state are unchanged. In LOCKED with random data -> locked stays 1, and words pass with data_vld cadence of 1 per 4 cycles.
